idct_2d_pipeline: RTL and testbench

- Streaming 8x8 2-D inverse DCT. It is the decode-side counterpart of the forward DCT pipeline.
- Input: one row of eight 12-bit signed coefficients per beat.
- Processing:
  - Row (horizontal) 1-D IDCT.
  - Ping-pong transpose buffer.
  - Column (vertical) 1-D IDCT.
  - Second ping-pong transpose buffer, so output is in raster row order.
- Output: one row of eight 8-bit pixels per beat. Sits between the coefficient source and the pixel sink.

---
 rtl/idct_2d_pipeline_if.sv | 25 ++
 rtl/idct_2d_pipeline.sv | 185 ++++++++++++++++++
 tb/tb_idct_2d_pipeline.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idct_2d_pipeline_if.sv
// Streaming bus of the 8x8 2-D IDCT: one coefficient row in, one pixel row out,
// plus the beat counters.
interface idct_2d_pipeline_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
);
  logic                  in_valid;
  logic                  in_first;
  logic [8*IN_W-1:0]     data_in;
  logic                  out_valid;
  logic                  out_first;
  logic [8*OUT_W-1:0]    data_out;
  logic [14:0]           cnt_in;
  logic [14:0]           cnt_out;

  modport master (
    output in_valid, in_first, data_in,
    input  out_valid, out_first, data_out, cnt_in, cnt_out
  );

  modport slave (
    input  in_valid, in_first, data_in,
    output out_valid, out_first, data_out, cnt_in, cnt_out
  );
endinterface

// File: rtl/idct_2d_pipeline.sv
// Streaming 8x8 2-D inverse DCT: row IDCT -> ping-pong transpose -> column IDCT
// -> ping-pong pixel buffer, emitting raster-order pixel rows.
module idct_2d_pipeline #(
  parameter int IN_W   = 12,
  parameter int MID_W  = 17,
  parameter int OUT_W  = 8,
  parameter int K_FRAC = 12
) (
  input logic               clk,
  input logic               reset,
  idct_2d_pipeline_if.slave bus
);
  localparam int MID_FRAC = 3;
  localparam int ROW_SH   = K_FRAC - MID_FRAC;
  localparam int COL_SH   = K_FRAC + MID_FRAC;
  localparam int ACC_W    = 36;
  localparam logic signed [ACC_W-1:0] ROW_RND = ACC_W'(32'sd1 <<< (ROW_SH - 32'sd1));
  localparam logic signed [ACC_W-1:0] COL_RND = ACC_W'(32'sd1 <<< (COL_SH - 32'sd1));
  localparam logic signed [ACC_W-1:0] PIX_MID = ACC_W'(32'sd1 <<< (OUT_W - 32'sd1));
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((32'sd1 <<< OUT_W) - 32'sd1);

  // Cosine constant K(k,n); the angle (2n+1)k*pi/16 is folded onto 0..pi/2.
  function automatic logic signed [12:0] kcos(input int k, input int n);
    int                 a;
    logic               neg;
    logic signed [12:0] mag;
    a   = ((32'sd2 * n + 32'sd1) * k) % 32'sd32;
    neg = 1'b0;
    if (a > 32'sd16) a = 32'sd32 - a;
    if (a > 32'sd8) begin
      neg = 1'b1;
      a   = 32'sd16 - a;
    end
    case (a)
      32'sd0:  mag = 13'sd2048;
      32'sd1:  mag = 13'sd2009;
      32'sd2:  mag = 13'sd1892;
      32'sd3:  mag = 13'sd1703;
      32'sd4:  mag = 13'sd1448;
      32'sd5:  mag = 13'sd1138;
      32'sd6:  mag = 13'sd784;
      32'sd7:  mag = 13'sd400;
      default: mag = 13'sd0;
    endcase
    if (k == 32'sd0) return 13'sd1448;
    else             return neg ? -mag : mag;
  endfunction

  function automatic logic signed [MID_W-1:0] row_dot(input logic [8*IN_W-1:0] x, input int n);
    logic signed [ACC_W-1:0] acc;
    acc = ROW_RND;
    for (int v = 0; v < 8; v++)
      acc = acc + ACC_W'($signed(x[v*IN_W +: IN_W])) * ACC_W'(kcos(v, n));
    return MID_W'(acc >>> ROW_SH);
  endfunction

  function automatic logic [OUT_W-1:0] col_pix(input logic [8*MID_W-1:0] y, input int m);
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] s;
    acc = COL_RND;
    for (int u = 0; u < 8; u++)
      acc = acc + ACC_W'($signed(y[u*MID_W +: MID_W])) * ACC_W'(kcos(u, m));
    s = (acc >>> COL_SH) + PIX_MID;
    if (s < 0)            return '0;
    else if (s > PIX_MAX) return '1;
    else                  return OUT_W'(s);
  endfunction

  logic [8*IN_W-1:0]  x_q;
  logic               in_vld_q, in_first_q;
  logic [2:0]         row_idx_q;
  logic               wr_sel_q;
  logic               col_active_q, col_sel_q, wb_sel_q;
  logic [2:0]         col_j_q;
  logic               out_active_q, out_sel_q;
  logic [2:0]         out_m_q;
  logic               out_valid_q, out_first_q;
  logic [8*OUT_W-1:0] data_out_q;
  logic [14:0]        cnt_in_q, cnt_out_q;

  logic [8*MID_W-1:0] bank_a_q [2][8];
  logic [OUT_W-1:0]   bank_b_q [2][8][8];

  logic [2:0]         row_sel_s;
  logic               row_last_s, col_last_s;
  logic [8*MID_W-1:0] y_row_s, col_vec_s;
  logic [8*OUT_W-1:0] pix_col_s, out_row_s;

  // Row placement and phase-end strobes; in_first restarts the current bank.
  always_comb begin
    if (in_first_q) row_sel_s = 3'd0;
    else            row_sel_s = row_idx_q;
    row_last_s = in_vld_q && (row_sel_s == 3'd7);
    col_last_s = col_active_q && (col_j_q == 3'd7);
  end

  // Datapaths: row IDCT of the registered beat, column IDCT of the full A bank, B row read.
  always_comb begin
    y_row_s   = '0;
    col_vec_s = '0;
    pix_col_s = '0;
    out_row_s = '0;
    for (int i = 0; i < 8; i++) begin
      y_row_s[i*MID_W +: MID_W]   = row_dot(x_q, i);
      col_vec_s[i*MID_W +: MID_W] = bank_a_q[col_sel_q][i][int'(col_j_q)*MID_W +: MID_W];
      out_row_s[i*OUT_W +: OUT_W] = bank_b_q[out_sel_q][out_m_q][i];
    end
    for (int i = 0; i < 8; i++)
      pix_col_s[i*OUT_W +: OUT_W] = col_pix(col_vec_s, i);
  end

  // Transpose buffers carry no reset; control state decides when their contents matter.
  always_ff @(posedge clk) begin
    if (in_vld_q) bank_a_q[wr_sel_q][row_sel_s] <= y_row_s;
    if (col_active_q)
      for (int m = 0; m < 8; m++)
        bank_b_q[wb_sel_q][m][col_j_q] <= pix_col_s[m*OUT_W +: OUT_W];
  end

  // Input capture, bank sequencing, column/output phase counters and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q          <= '0;
      in_vld_q     <= 1'b0;
      in_first_q   <= 1'b0;
      row_idx_q    <= 3'd0;
      wr_sel_q     <= 1'b0;
      col_active_q <= 1'b0;
      col_j_q      <= 3'd0;
      col_sel_q    <= 1'b0;
      wb_sel_q     <= 1'b0;
      out_active_q <= 1'b0;
      out_m_q      <= 3'd0;
      out_sel_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      data_out_q   <= '0;
      cnt_in_q     <= 15'd0;
      cnt_out_q    <= 15'd0;
    end else begin
      in_vld_q   <= bus.in_valid;
      in_first_q <= bus.in_valid & bus.in_first;
      if (bus.in_valid) begin
        x_q      <= bus.data_in;
        cnt_in_q <= cnt_in_q + 15'd1;
      end

      if (in_vld_q) row_idx_q <= row_sel_s + 3'd1;
      if (row_last_s) wr_sel_q <= ~wr_sel_q;

      // A fresh full bank restarts the column pass even on the cycle the previous one ends.
      if (row_last_s) begin
        col_active_q <= 1'b1;
        col_j_q      <= 3'd0;
        col_sel_q    <= wr_sel_q;
      end else if (col_active_q) begin
        col_j_q <= col_j_q + 3'd1;
        if (col_j_q == 3'd7) col_active_q <= 1'b0;
      end

      if (col_last_s) begin
        wb_sel_q     <= ~wb_sel_q;
        out_active_q <= 1'b1;
        out_m_q      <= 3'd0;
        out_sel_q    <= wb_sel_q;
      end else if (out_active_q) begin
        out_m_q <= out_m_q + 3'd1;
        if (out_m_q == 3'd7) out_active_q <= 1'b0;
      end

      out_valid_q <= out_active_q;
      out_first_q <= out_active_q && (out_m_q == 3'd0);
      if (out_active_q) begin
        data_out_q <= out_row_s;
        cnt_out_q  <= cnt_out_q + 15'd1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.data_out  = data_out_q;
  assign bus.cnt_in    = cnt_in_q;
  assign bus.cnt_out   = cnt_out_q;
endmodule

// File: tb/tb_idct_2d_pipeline.sv
// Scoreboard bench for idct_2d_pipeline: expected pixel rows are queued as blocks
// are driven and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_idct_2d_pipeline;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  idct_2d_pipeline_if bus();
  idct_2d_pipeline dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [63:0] pix;
    logic        first;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] cap_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int first_cyc = -1000;
  int prev_first_cyc = -1000;
  int t_row0 = 0;
  int t_row7 = 0;
  int kk[8][8];
  int xb[8][8];
  int xs[2][8][8];
  logic [63:0] gold[8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic void init_k();
    real c;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        kk[k][n] = rnd(4096.0 * c / 2.0 * $cos((2 * n + 1) * k * PI / 16.0));
      end
  endfunction

  function automatic void gold_block();
    int y[8][8];
    int acc;
    longint lacc;
    longint s;
    for (int u = 0; u < 8; u++)
      for (int n = 0; n < 8; n++) begin
        acc = 256;
        for (int v = 0; v < 8; v++) acc += xb[u][v] * kk[v][n];
        y[u][n] = acc >>> 9;
      end
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++) begin
        lacc = 64'sd16384;
        for (int u = 0; u < 8; u++) lacc += longint'(y[u][n]) * longint'(kk[u][m]);
        s = (lacc >>> 15) + 128;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        gold[m][n*8 +: 8] = 8'(s);
      end
  endfunction

  function automatic int dbl_pix(int b, int m, int n);
    real acc, cu, cv;
    acc = 0.0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        acc += cu * cv / 4.0 * xs[b][u][v] * $cos((2 * m + 1) * u * PI / 16.0)
               * $cos((2 * n + 1) * v * PI / 16.0);
      end
    acc = $floor(acc + 128.0 + 0.5);
    if (acc < 0.0) acc = 0.0;
    if (acc > 255.0) acc = 255.0;
    return $rtoi(acc);
  endfunction

  function automatic void rand_block();
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        xb[u][v] = (u == 0 && v == 0) ? int'($urandom_range(1023, 0)) - 512
                                      : int'($urandom_range(127, 0)) - 64;
  endfunction

  function automatic void clear_block();
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) xb[u][v] = 0;
  endfunction

  function automatic void push_const(logic [7:0] p);
    exp_t e;
    for (int m = 0; m < 8; m++) begin
      e.pix   = {8{p}};
      e.first = (m == 0);
      sb_q.push_back(e);
    end
  endfunction

  function automatic void push_gold();
    exp_t e;
    gold_block();
    for (int m = 0; m < 8; m++) begin
      e.pix   = gold[m];
      e.first = (m == 0);
      sb_q.push_back(e);
    end
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.out_valid === 1'b1) begin
        beats++;
        cap_q.push_back(bus.data_out);
        if (bus.out_first === 1'b1) begin
          prev_first_cyc = first_cyc;
          first_cyc      = cyc;
        end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got data=%h first=%b, none expected", bus.data_out, bus.out_first);
        end else begin
          e = sb_q.pop_front();
          if (bus.data_out !== e.pix || bus.out_first !== e.first) begin
            errors++;
            $display("FAIL sb_row got data=%h first=%b expected data=%h first=%b",
                     bus.data_out, bus.out_first, e.pix, e.first);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.data_in  = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    cap_q.delete();
    beats = 0;
    first_cyc = -1000;
    reset = 1'b1;
  endtask

  task automatic send_row(int u, logic first);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_first = first;
    for (int v = 0; v < 8; v++) bus.data_in[v*12 +: 12] = 12'(xb[u][v]);
    if (u == 0) t_row0 = cyc + 1;
    if (u == 7) t_row7 = cyc + 1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  task automatic send_block(int gap);
    for (int u = 0; u < 8; u++) begin
      send_row(u, u == 0);
      if (gap != 0) idle();
    end
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d rows still pending, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_first !== 1'b0 || bus.data_out !== 64'd0 ||
        bus.cnt_in !== 15'd0 || bus.cnt_out !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b f=%b d=%h ci=%0d co=%0d expected all zero",
               bus.out_valid, bus.out_first, bus.data_out, bus.cnt_in, bus.cnt_out);
    end
    reset = 1'b1;
  endtask

  task automatic test_zero_block();
    do_reset();
    clear_block();
    push_const(8'd128);
    send_block(0);
    idle();
    wait_drain("zero");
    checks++;
    if (first_cyc - t_row0 !== 17) begin
      errors++;
      $display("FAIL zero_latency got %0d edges, expected 17", first_cyc - t_row0);
    end
    checks++;
    if (bus.cnt_in !== 15'd8 || bus.cnt_out !== 15'd8) begin
      errors++;
      $display("FAIL zero_counts got in=%0d out=%0d, expected 8/8", bus.cnt_in, bus.cnt_out);
    end
  endtask

  task automatic test_dc();
    int dc[3] = '{64, 2047, -2048};
    logic [7:0] px[3] = '{8'd136, 8'd255, 8'd0};
    for (int i = 0; i < 3; i++) begin
      clear_block();
      xb[0][0] = dc[i];
      push_const(px[i]);
      send_block(0);
      idle();
      wait_drain("dc");
    end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [63:0] row;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      rand_block();
      for (int u = 0; u < 8; u++)
        for (int v = 0; v < 8; v++) xs[b][u][v] = xb[u][v];
      push_gold();
      send_block(0);
    end
    idle();
    wait_drain("b2b");
    checks++;
    if (first_cyc - prev_first_cyc !== 8 || beats !== 16) begin
      errors++;
      $display("FAIL b2b_gap got spacing=%0d beats=%0d, expected 8/16", first_cyc - prev_first_cyc, beats);
    end
    for (int r = 0; r < 16 && cap_q.size() != 0; r++) begin
      row = cap_q.pop_front();
      checks++;
      for (int n = 0; n < 8; n++) begin
        d = int'(row[n*8 +: 8]) - dbl_pix(r / 8, r % 8, n);
        if (d > 1 || d < -1) begin
          errors++;
          $display("FAIL b2b_double row %0d col %0d got %0d, expected %0d +-1",
                   r, n, row[n*8 +: 8], dbl_pix(r / 8, r % 8, n));
          break;
        end
      end
    end
  endtask

  task automatic test_gapped();
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) xb[u][v] = xs[0][u][v];
    push_gold();
    send_block(1);
    idle();
    wait_drain("gap");
    checks++;
    if (first_cyc - t_row7 !== 10) begin
      errors++;
      $display("FAIL gap_latency got %0d edges after row 7, expected 10", first_cyc - t_row7);
    end
  endtask

  task automatic test_in_first();
    do_reset();
    rand_block();
    for (int u = 0; u < 3; u++) send_row(u, u == 0);
    rand_block();
    push_gold();
    send_block(0);
    idle();
    wait_drain("restart");
    checks++;
    if (bus.cnt_in !== 15'd11 || bus.cnt_out !== 15'd8 || beats !== 8) begin
      errors++;
      $display("FAIL restart_counts got in=%0d out=%0d beats=%0d, expected 11/8/8",
               bus.cnt_in, bus.cnt_out, beats);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    rand_block();
    push_gold();
    send_block(0);
    idle();
    while (beats < 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (beats < 3) begin
      errors++;
      $display("FAIL mid_wait got %0d beats, expected at least 3", beats);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cnt_in !== 15'd0 || bus.cnt_out !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b ci=%0d co=%0d, expected 0/0/0", bus.out_valid, bus.cnt_in, bus.cnt_out);
    end
    sb_q.delete();
    repeat (2) @(negedge clk);
    beats = 0;
    first_cyc = -1000;
    reset = 1'b1;
    rand_block();
    push_gold();
    send_block(0);
    idle();
    wait_drain("post_reset");
    checks++;
    if (first_cyc - t_row0 !== 17 || beats !== 8) begin
      errors++;
      $display("FAIL post_reset_latency got %0d edges beats=%0d, expected 17/8", first_cyc - t_row0, beats);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.data_in  = '0;
    init_k();
    fork
      monitor();
    join_none
    test_reset();
    test_zero_block();
    test_dc();
    test_back_to_back();
    test_gapped();
    test_in_first();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
